// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared stage-1 fetch control definitions: FSM state encodings, PC_Sel
// encodings, boot counter sizing and a small helper for the boot terminal
// count.
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    FETCH_BOOT   = 2'd0,
    FETCH_REQ    = 2'd1,
    FETCH_WAIT   = 2'd2,
    FETCH_SQUASH = 2'd3
  } fetch_state_e;

  // PC_Sel encodings seen by the PC register.
  localparam logic PC_SEL_PLUS4 = 1'b0;
  localparam logic PC_SEL_ALU   = 1'b1;

  // Boot counter is wide enough for the legal hold range 1..15.
  localparam int BOOT_CNT_W = 4;

  // Terminal value of the boot counter: BOOT is left on the edge where the
  // counter equals hold-1, so pc_reset stays high for exactly 'hold' edges.
  function automatic logic [BOOT_CNT_W-1:0] boot_last(input int hold);
    return BOOT_CNT_W'(hold - 1);
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up-counter that increments by one on each enabled clock and sticks at
// all-ones instead of wrapping. Cleared only by the async active-low clear.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low clear
//   en_i   : increment enable
//   cnt_o  : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment when enabled unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Stage-1 fetch sequencer. Drives the PC register controls, runs a
// one-outstanding request/response handshake with IMEM, applies execute-stage
// redirects and marks stale responses for decode to drop.
//   clk              : system clock, rising edge
//   reset            : asynchronous active-low reset
//   redirect_valid   : taken branch/jump resolved, target on ALU_Out
//   hazard_stall     : downstream stall, blocks new requests only
//   imem_req_ready   : IMEM accepts a request this cycle
//   imem_resp_valid  : IMEM returns an instruction this cycle
//   imem_req_valid   : fetch request for current PC_Out (combinational)
//   pc_sel           : PC_Sel, 1 = load ALU_Out, 0 = PC+4 (combinational)
//   pc_stall         : PC hold (combinational)
//   pc_reset         : PC reset, active-high (registered)
//   inst_valid       : response is live for decode (combinational)
//   inst_kill        : response is stale, drop it (combinational)
//   stall_cycles     : saturating count of fetch-stall cycles (registered)
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid,
  input  logic             hazard_stall,
  input  logic             imem_req_ready,
  input  logic             imem_resp_valid,
  output logic             imem_req_valid,
  output logic             pc_sel,
  output logic             pc_stall,
  output logic             pc_reset,
  output logic             inst_valid,
  output logic             inst_kill,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = boot_last(RESET_HOLD_CYCLES);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [BOOT_CNT_W-1:0] boot_cnt_q;
  logic [BOOT_CNT_W-1:0] boot_cnt_d;
  logic                  pc_reset_q;
  logic                  pc_reset_d;
  logic                  req_go;
  logic                  stall_cnt_en;

  // A new request is only offered when nothing higher priority is pending.
  assign req_go = !hazard_stall && !redirect_valid;

  // Next-state and combinational outputs of the fetch FSM.
  always_comb begin
    state_d        = state_q;
    boot_cnt_d     = boot_cnt_q;
    imem_req_valid = 1'b0;
    pc_sel         = PC_SEL_PLUS4;
    pc_stall       = 1'b1;
    inst_valid     = 1'b0;
    inst_kill      = 1'b0;

    case (state_q)
      FETCH_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = FETCH_REQ;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      FETCH_REQ: begin
        // Responses here are protocol violations and are ignored.
        imem_req_valid = req_go;
        if (redirect_valid) begin
          // Load the target now; it is requested on the following cycle.
          pc_sel   = PC_SEL_ALU;
          pc_stall = 1'b0;
        end else if (req_go && imem_req_ready) begin
          pc_stall = 1'b0;
          state_d  = FETCH_WAIT;
        end else begin
          pc_stall = 1'b1;
        end
      end

      FETCH_WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            // Response belongs to the wrong path; drop it and redirect.
            inst_kill = 1'b1;
            pc_sel    = PC_SEL_ALU;
            pc_stall  = 1'b0;
          end else begin
            inst_valid = 1'b1;
          end
          state_d = FETCH_REQ;
        end else if (redirect_valid) begin
          // Request still in flight: its response must be squashed later.
          pc_sel   = PC_SEL_ALU;
          pc_stall = 1'b0;
          state_d  = FETCH_SQUASH;
        end else begin
          state_d = FETCH_WAIT;
        end
      end

      FETCH_SQUASH: begin
        if (redirect_valid) begin
          // Newest target wins.
          pc_sel   = PC_SEL_ALU;
          pc_stall = 1'b0;
        end else begin
          pc_stall = 1'b1;
        end
        if (imem_resp_valid) begin
          inst_kill = 1'b1;
          state_d   = FETCH_REQ;
        end else begin
          state_d = FETCH_SQUASH;
        end
      end

      default: begin
        state_d = FETCH_BOOT;
      end
    endcase

    // pc_reset tracks BOOT one register stage ahead so it falls on exit edge.
    pc_reset_d = (state_d == FETCH_BOOT);
  end

  // State, boot counter and registered PC reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH_BOOT;
      boot_cnt_q <= {BOOT_CNT_W{1'b0}};
      pc_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_reset_q <= pc_reset_d;
    end
  end

  assign pc_reset = pc_reset_q;

  // Boot-time PC hold is not a fetch stall.
  assign stall_cnt_en = pc_stall && (state_q != FETCH_BOOT);

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (stall_cnt_en),
    .cnt_o (stall_cycles)
  );

endmodule
